bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 27: binary input width; 2^27 covers 0..99,999,999.
REQ-002 Parameter DIGITS, default 8: number of BCD digit outputs, num0 (least significant) to num7.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port bin, input, WIDTH bits: unsigned binary operand, sampled only when a start is accepted.
REQ-006 Port start, input, 1 bit: conversion request, level-sampled each cycle.
REQ-007 Port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 Port done, output, 1 bit: one-cycle pulse when new digits are valid.
REQ-009 Port ovf, output, 1 bit: the last accepted operand exceeded 99,999,999.
REQ-010 Ports num0..num7, output, 4 bits each: registered BCD digits, directly consumable by the 7-segment display decoder.

Function
REQ-011 FSM states: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1: capture bin into a shift register, clear the BCD scratch register, load iteration counter with WIDTH, enter SHIFT.
REQ-013 IDLE with start=0: remain in IDLE; outputs hold.
REQ-014 SHIFT, each cycle: add 3 to every scratch digit >=5, then shift {scratch, shift register} left by 1 and decrement the counter.
REQ-015 SHIFT exits to DONE on the cycle the counter reaches 0, after exactly WIDTH SHIFT cycles.
REQ-016 DONE, one cycle: write scratch digits to num0..num7, set ovf, assert done=1, return to IDLE.
REQ-017 Latency: done high exactly WIDTH+1 cycles after the edge that accepted start (28 cycles at default).
REQ-018 busy=1 in SHIFT and DONE; busy=0 in IDLE.
REQ-019 start is ignored while busy=1; no queuing.
REQ-020 start high in the DONE cycle is ignored; start high on the following IDLE cycle is accepted, giving back-to-back conversions every WIDTH+2 cycles.
REQ-021 Overflow: if the captured operand > 99,999,999, the DONE update forces every digit to 9 and sets ovf=1.
REQ-022 No overflow: ovf=0 at DONE.
REQ-023 num0..num7 and ovf change only in DONE; they never show partial results.
REQ-024 Scratch-register width is 4*DIGITS; bits shifted beyond it are discarded, which is safe because overflow is detected from the captured operand.
REQ-025 X on bin while IDLE with start=0 has no effect on the outputs.

Reset
REQ-026 rst_n=0 asynchronously forces: state=IDLE, busy=0, done=0, ovf=0, num0..num7=0, counter=0, scratch and shift registers=0.
REQ-027 Reset mid-conversion aborts the conversion; no done pulse is produced for it.
REQ-028 After rst_n deasserts, the first rising edge with start=1 is accepted normally.

Structure
REQ-029 Shared package bin2bcd_pkg holds: state enum (IDLE, SHIFT, DONE), BCD_MAX constant 99,999,999, and a 4-bit bcd_digit_t typedef.
REQ-030 One sub-module, bcd_add3: 4-bit combinational "add 3 if >=5" cell, instantiated DIGITS times.
REQ-031 All outputs are registered; no combinational path from bin or start to any output.

Verification
REQ-032 Reset, then bin=0, start pulse -> busy for 28 cycles; done at cycle 28; all digits 0; ovf=0.
REQ-033 bin=12,345,678 -> num7..num0 = 1,2,3,4,5,6,7,8; done 28 cycles after start.
REQ-034 bin=99,999,999 -> all digits 9, ovf=0; then bin=100,000,000 -> all digits 9, ovf=1.
REQ-035 Start a conversion of 42, then hold start=1 with bin=7 throughout -> first result 42 with done at cycle 28; second conversion accepted at cycle 29; result 7 with done at cycle 57.
REQ-036 Start bin=555; assert rst_n=0 at cycle 10 -> outputs 0 immediately; no done pulse; a new start after release converts correctly.
REQ-037 1000 random operands in 0..2^27-1 checked against a reference model: digits, ovf, and exact done timing.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t     : converter FSM states
//   bcd_digit_t : one packed BCD digit
//   BCD_MAX     : largest operand that fits in eight decimal digits
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned BCD_MAX    = 99_999_999;
  localparam int unsigned NUM_PORTS  = 8;
  localparam bcd_digit_t  DIGIT_NINE = 4'd9;

  // Double-dabble correction: a digit of 5..9 would carry wrongly after the shift.
  function automatic bcd_digit_t add3_ge5(bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result bundle between a requester and the binary-to-BCD converter.
//   bin, start          : operand and conversion request (requester -> converter)
//   busy, done, ovf     : status (converter -> requester)
//   num0..num7          : BCD result digits, num0 least significant
interface bin2bcd_if
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 27
);

  logic [WIDTH-1:0] bin;
  logic             start;
  logic             busy;
  logic             done;
  logic             ovf;
  bcd_digit_t       num0, num1, num2, num3, num4, num5, num6, num7;

  modport master (
    output bin, start,
    input  busy, done, ovf,
    input  num0, num1, num2, num3, num4, num5, num6, num7
  );

  modport slave (
    input  bin, start,
    output busy, done, ovf,
    output num0, num1, num2, num3, num4, num5, num6, num7
  );

endinterface

// File: rtl/bcd_add3.sv
// Combinational double-dabble cell: adds 3 to a BCD digit that is 5 or more.
//   d_in    : current scratch digit
//   d_out_c : corrected digit, ready to be shifted left
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t d_in,
  output bcd_digit_t d_out_c
);

  assign d_out_c = add3_ge5(d_in);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.bin    : operand, captured only when a start is accepted in IDLE
//   bus.start  : level-sampled conversion request, ignored while busy
//   bus.busy   : high in SHIFT and DONE
//   bus.done   : one-cycle pulse when num0..num7 / ovf are updated
//   bus.ovf    : last accepted operand was above 99,999,999 (digits forced to 9)
//   bus.num*   : registered BCD digits, updated only at the end of a conversion
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 27,
  parameter int unsigned DIGITS = 8
)(
  input  logic       clk,
  input  logic       rst_n,
  bin2bcd_if.slave   bus
);

  localparam int unsigned SCR_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t                          state_q, state_d;
  logic [WIDTH-1:0]                shreg_q, shreg_d;
  logic [SCR_W-1:0]                scratch_q, scratch_d;
  logic [SCR_W-1:0]                scratch_adj_c;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            ovf_pend_q, ovf_pend_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            ovf_q, ovf_d;
  bcd_digit_t [NUM_PORTS-1:0]      num_q, num_d;

  // Per-digit add-3 correction applied to the scratch register before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_in    (scratch_q[4*g +: 4]),
      .d_out_c (scratch_adj_c[4*g +: 4])
    );
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    num_d      = num_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d    = bus.bin;
          scratch_d  = '0;
          cnt_d      = CNT_W'(WIDTH);
          // Overflow comes from the operand itself, so bits lost off the
          // top of the scratch register never matter.
          ovf_pend_d = (64'(bus.bin) > 64'(BCD_MAX));
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        {scratch_d, shreg_d} = {scratch_adj_c, shreg_q} << 1;
        cnt_d                = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (ovf_pend_q) begin
            num_d[i] = DIGIT_NINE;
          end else if (i < DIGITS) begin
            num_d[i] = scratch_q[4*i +: 4];
          end else begin
            num_d[i] = '0;
          end
        end
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      num_q      <= num_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.num0 = num_q[0];
  assign bus.num1 = num_q[1];
  assign bus.num2 = num_q[2];
  assign bus.num3 = num_q[3];
  assign bus.num4 = num_q[4];
  assign bus.num5 = num_q[5];
  assign bus.num6 = num_q[6];
  assign bus.num7 = num_q[7];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomised checks of bin2bcd_seq: reset, conversions,
// overflow boundary, back-to-back starts, reset abort, done timing.
module tb_bin2bcd_seq;

  localparam int unsigned WIDTH = 27;
  localparam int          LAT   = 28;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bin2bcd_if #(.WIDTH(WIDTH)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get_digits();
    return {bus.num7, bus.num6, bus.num5, bus.num4,
            bus.num3, bus.num2, bus.num1, bus.num0};
  endfunction

  // Reference: decimal digits by division, saturating to all nines.
  function automatic logic [31:0] model_bcd(input int unsigned v);
    logic [31:0]  r;
    int unsigned  t;
    r = '0;
    t = v;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One conversion from IDLE; reports latency, busy cycles, result and
  // the done level one cycle after the pulse. lat = -1 when done never came.
  task automatic run_conv(input logic [WIDTH-1:0] v, output int lat, output int busy_n,
                          output logic [31:0] dig, output logic ovf, output logic done_after);
    lat        = -1;
    busy_n     = 0;
    dig        = '0;
    ovf        = 1'b0;
    done_after = 1'b1;
    bus.bin    = v;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bin    = 'x;
    if (bus.busy) busy_n++;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = c;
        dig = get_digits();
        ovf = bus.ovf;
      end
    end
    @(posedge clk); #1;
    done_after = bus.done;
    bus.bin    = '0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    total++; if (get_digits() !== 32'h0) begin bad++; $display("FAIL reset_digits got=%h exp=00000000", get_digits()); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_hold();
    logic seen;
    seen    = 1'b0;
    bus.bin = 'x;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen = 1'b1;
    end
    bus.bin = '0;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL idle_hold activity got=%b exp=0", seen); end
    total++; if (get_digits() !== 32'h0) begin bad++; $display("FAIL idle_hold_digits got=%h exp=00000000", get_digits()); end
  endtask

  task automatic test_zero();
    int lat, bn; logic [31:0] d; logic o, da;
    run_conv(27'd0, lat, bn, d, o, da);
    total++; if (lat !== LAT) begin bad++; $display("FAIL zero_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (bn !== LAT) begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=%0d", bn, LAT); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL zero_digits got=%h exp=00000000", d); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL zero_ovf got=%b exp=0", o); end
    total++; if (da !== 1'b0) begin bad++; $display("FAIL zero_done_pulse_width got=%b exp=0", da); end
  endtask

  task automatic test_convert();
    int lat, bn; logic [31:0] d; logic o, da;
    run_conv(27'd12_345_678, lat, bn, d, o, da);
    total++; if (lat !== LAT) begin bad++; $display("FAIL conv_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL conv_12345678 got=%h exp=12345678", d); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL conv_ovf got=%b exp=0", o); end
    run_conv(27'd90_817_065, lat, bn, d, o, da);
    total++; if (d !== 32'h9081_7065) begin bad++; $display("FAIL conv_90817065 got=%h exp=90817065", d); end
  endtask

  task automatic test_overflow();
    int lat, bn; logic [31:0] d; logic o, da;
    run_conv(27'd99_999_999, lat, bn, d, o, da);
    total++; if (d !== 32'h9999_9999) begin bad++; $display("FAIL max_digits got=%h exp=99999999", d); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL max_ovf got=%b exp=0", o); end
    run_conv(27'd100_000_000, lat, bn, d, o, da);
    total++; if (d !== 32'h9999_9999) begin bad++; $display("FAIL ovf_digits got=%h exp=99999999", d); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", o); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL ovf_latency got=%0d exp=%0d", lat, LAT); end
    run_conv(27'h7FF_FFFF, lat, bn, d, o, da);
    total++; if (o !== 1'b1) begin bad++; $display("FAIL ovf_top_flag got=%b exp=1", o); end
    run_conv(27'd5, lat, bn, d, o, da);
    total++; if (d !== 32'h0000_0005) begin bad++; $display("FAIL after_ovf_digits got=%h exp=00000005", d); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL after_ovf_flag got=%b exp=0", o); end
  endtask

  task automatic test_back_to_back();
    int d1, d2; logic [31:0] g1, g2; logic b28, b29;
    d1 = -1; d2 = -1; g1 = '0; g2 = '0; b28 = 1'bx; b29 = 1'bx;
    bus.bin   = 27'd42;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.bin = 27'd7;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 28) b28 = bus.busy;
      if (c == 29) b29 = bus.busy;
      if (bus.done) begin
        if (d1 < 0) begin d1 = c; g1 = get_digits(); end
        else if (d2 < 0) begin d2 = c; g2 = get_digits(); end
      end
      if (c == 57) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    bus.bin   = '0;
    total++; if (d1 !== 28) begin bad++; $display("FAIL b2b_first_done got=%0d exp=28", d1); end
    total++; if (g1 !== 32'h0000_0042) begin bad++; $display("FAIL b2b_first_digits got=%h exp=00000042", g1); end
    total++; if (b28 !== 1'b0) begin bad++; $display("FAIL b2b_busy_c28 got=%b exp=0", b28); end
    total++; if (b29 !== 1'b1) begin bad++; $display("FAIL b2b_busy_c29 got=%b exp=1", b29); end
    total++; if (d2 !== 57) begin bad++; $display("FAIL b2b_second_done got=%0d exp=57", d2); end
    total++; if (g2 !== 32'h0000_0007) begin bad++; $display("FAIL b2b_second_digits got=%h exp=00000007", g2); end
  endtask

  task automatic test_reset_abort();
    int lat, bn; logic [31:0] d; logic o, da, seen;
    seen      = 1'b0;
    bus.bin   = 27'd555;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    total++; if (get_digits() !== 32'h0) begin bad++; $display("FAIL abort_digits got=%h exp=00000000", get_digits()); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_spurious_done got=%b exp=0", seen); end
    run_conv(27'd555, lat, bn, d, o, da);
    total++; if (lat !== LAT) begin bad++; $display("FAIL abort_restart_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (d !== 32'h0000_0555) begin bad++; $display("FAIL abort_restart_digits got=%h exp=00000555", d); end
  endtask

  task automatic test_random();
    int lat, bn; logic [31:0] d, e; logic o, da, eo;
    int unsigned v;
    for (int n = 0; n < 1000; n++) begin
      v  = $urandom_range(32'd134_217_727, 32'd0);
      e  = model_bcd(v);
      eo = (v > 32'd99_999_999);
      run_conv(WIDTH'(v), lat, bn, d, o, da);
      total++; if (lat !== LAT) begin bad++; $display("FAIL rand_latency v=%0d got=%0d exp=%0d", v, lat, LAT); end
      total++; if (d !== e) begin bad++; $display("FAIL rand_digits v=%0d got=%h exp=%h", v, d, e); end
      total++; if (o !== eo) begin bad++; $display("FAIL rand_ovf v=%0d got=%b exp=%b", v, o, eo); end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    #2;
    test_reset();
    test_idle_hold();
    test_zero();
    test_convert();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
